pim_matmul_agu: RTL and testbench

- Memory-side responder for the matrix-multiply command issued by the host/bench: src1_addr, src2_addr, dst_addr, matrix_size.
- Accepts one command at a time over a valid/ready handshake, then walks the operand matrices for C = A x B.
- Emits paired read addresses (A element, B element) and a result write address per C element, then signals done.
- Sits in front of the PIM memory array and MAC datapath; carries addresses only, no data.

---
 rtl/pim_matmul_agu.sv | 246 ++++++++++++++++++++++++
 tb/tb_pim_matmul_agu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_matmul_agu.sv
// Address generator for the PIM matrix-multiply engine: walks C = A x B.
// Define PIM_AGU_ALIGN_CHECK_EN to reject commands with misaligned bases.
module pim_matmul_agu #(
    parameter int ADDR_W     = 32,
    parameter int ELEM_BYTES = 4,
    parameter int SIZE_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [SIZE_W-1:0] matrix_size,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_first,
    output logic              rd_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SHIFT = $clog2(ELEM_BYTES);
    localparam int IW    = 2 * SIZE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_src1;
    logic [ADDR_W-1:0] r_src2;
    logic [ADDR_W-1:0] r_dst;
    logic [SIZE_W-1:0] r_nm1;
    logic [SIZE_W-1:0] r_i;
    logic [SIZE_W-1:0] r_j;
    logic [SIZE_W-1:0] r_k;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_w;

    logic              w_accept;
    logic              w_misalign;
    logic              w_start;
    logic              w_rd_hs;
    logic              w_wr_hs;
    logic              w_k_last;
    logic              w_j_last;
    logic              w_i_last;
    logic              w_load;

    logic [ADDR_W-1:0] w_src1_nxt;
    logic [ADDR_W-1:0] w_src2_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic [SIZE_W-1:0] w_nm1_nxt;
    logic [SIZE_W-1:0] w_i_nxt;
    logic [SIZE_W-1:0] w_j_nxt;
    logic [SIZE_W-1:0] w_k_nxt;
    logic [SIZE_W:0]   w_n;
    logic [IW-1:0]     w_idx_a;
    logic [IW-1:0]     w_idx_b;
    logic [IW-1:0]     w_idx_c;
    logic [ADDR_W-1:0] w_addr_a_nxt;
    logic [ADDR_W-1:0] w_addr_b_nxt;
    logic [ADDR_W-1:0] w_addr_w_nxt;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_rd_hs  = (r_state == S_READ) && rd_ready;
    assign w_wr_hs  = (r_state == S_WRITE) && wr_ready;
    assign w_k_last = (r_k == r_nm1);
    assign w_j_last = (r_j == r_nm1);
    assign w_i_last = (r_i == r_nm1);

`ifdef PIM_AGU_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(ELEM_BYTES - 1);

    logic r_err;

    assign w_misalign = |((src1_addr | src2_addr | dst_addr) & LOW_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_misalign;
        end
    end

    assign err = r_err;
`else
    assign w_misalign = 1'b0;
    assign err        = 1'b0;
`endif

    assign w_start = w_accept && !w_misalign;
    assign w_load  = w_start || w_rd_hs || w_wr_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_rd_hs && w_k_last) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_wr_hs) begin
                    w_state_nxt = (w_i_last && w_j_last) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        rd_valid  = 1'b0;
        wr_valid  = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_READ: begin
                rd_valid = 1'b1;
            end
            S_WRITE: begin
                wr_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rd_first  = rd_valid && (r_k == '0);
    assign rd_last   = rd_valid && w_k_last;
    assign rd_addr_a = r_addr_a;
    assign rd_addr_b = r_addr_b;
    assign wr_addr   = r_addr_w;

    // Indices/bases for the beat that follows the current handshake
    always_comb begin
        w_src1_nxt = r_src1;
        w_src2_nxt = r_src2;
        w_dst_nxt  = r_dst;
        w_nm1_nxt  = r_nm1;
        w_i_nxt    = r_i;
        w_j_nxt    = r_j;
        w_k_nxt    = r_k;
        if (w_start) begin
            w_src1_nxt = src1_addr;
            w_src2_nxt = src2_addr;
            w_dst_nxt  = dst_addr;
            w_nm1_nxt  = matrix_size;
            w_i_nxt    = '0;
            w_j_nxt    = '0;
            w_k_nxt    = '0;
        end else if (w_rd_hs) begin
            if (!w_k_last) begin
                w_k_nxt = r_k + 1'b1;
            end
        end else if (w_wr_hs) begin
            w_k_nxt = '0;
            if (!w_j_last) begin
                w_j_nxt = r_j + 1'b1;
            end else begin
                w_j_nxt = '0;
                if (!w_i_last) begin
                    w_i_nxt = r_i + 1'b1;
                end
            end
        end
    end

    assign w_n     = {1'b0, w_nm1_nxt} + (SIZE_W + 1)'(1);
    assign w_idx_a = IW'(w_i_nxt) * IW'(w_n) + IW'(w_k_nxt);
    assign w_idx_b = IW'(w_k_nxt) * IW'(w_n) + IW'(w_j_nxt);
    assign w_idx_c = IW'(w_i_nxt) * IW'(w_n) + IW'(w_j_nxt);

    assign w_addr_a_nxt = w_src1_nxt + (ADDR_W'(w_idx_a) << SHIFT);
    assign w_addr_b_nxt = w_src2_nxt + (ADDR_W'(w_idx_b) << SHIFT);
    assign w_addr_w_nxt = w_dst_nxt + (ADDR_W'(w_idx_c) << SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src1   <= '0;
            r_src2   <= '0;
            r_dst    <= '0;
            r_nm1    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_w <= '0;
        end else if (w_load) begin
            r_src1   <= w_src1_nxt;
            r_src2   <= w_src2_nxt;
            r_dst    <= w_dst_nxt;
            r_nm1    <= w_nm1_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_addr_a <= w_addr_a_nxt;
            r_addr_b <= w_addr_b_nxt;
            r_addr_w <= w_addr_w_nxt;
        end
    end

endmodule

// File: tb/tb_pim_matmul_agu.sv
// Directed bench for pim_matmul_agu with a reference address walker.
// Define PIM_AGU_ALIGN_CHECK_EN to also exercise the alignment reject path.
module tb_pim_matmul_agu;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] src1_addr;
    logic [31:0] src2_addr;
    logic [31:0] dst_addr;
    logic [2:0]  matrix_size;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_addr_a;
    logic [31:0] rd_addr_b;
    logic        rd_first;
    logic        rd_last;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    int          nrd;
    int          nwr;
    int          ndone;
    logic [31:0] spot_a;
    logic [31:0] spot_b;
    logic [31:0] last_wr;
    logic [31:0] a0;
    logic [31:0] a1;

    pim_matmul_agu #(
        .ADDR_W     (32),
        .ELEM_BYTES (4),
        .SIZE_W     (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .src1_addr   (src1_addr),
        .src2_addr   (src2_addr),
        .dst_addr    (dst_addr),
        .matrix_size (matrix_size),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_first    (rd_first),
        .rd_last     (rd_last),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and follows it with a reference i/j/k walker
    task automatic run_cmd(input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] d, input logic [2:0] sz,
                           input bit stall);
        int n;
        int i;
        int j;
        int k;
        int ph;
        int cyc;
        bit fin;
        n = int'(sz) + 1;
        i = 0; j = 0; k = 0; ph = 0; cyc = 0; fin = 0;
        nrd = 0; nwr = 0; ndone = 0;
        chk("pre_ready", cmd_ready, 1);
        cmd_valid   = 1'b1;
        src1_addr   = s1;
        src2_addr   = s2;
        dst_addr    = d;
        matrix_size = sz;
        step();
        cmd_valid   = 1'b0;
        src1_addr   = ~s1;
        src2_addr   = ~s2;
        dst_addr    = ~d;
        matrix_size = ~sz;
        while (!fin && cyc < 5000) begin
            rd_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            chk("rd_valid", rd_valid, (ph == 0) ? 1 : 0);
            chk("wr_valid", wr_valid, (ph == 1) ? 1 : 0);
            chk("done", done, (ph == 2) ? 1 : 0);
            chk("busy", busy, 1);
            chk("err", err, 0);
            if (ph == 0) begin
                chk("addr_a", rd_addr_a, s1 + 32'((i * n + k) * 4));
                chk("addr_b", rd_addr_b, s2 + 32'((k * n + j) * 4));
                chk("first", rd_first, (k == 0) ? 1 : 0);
                chk("last", rd_last, (k == n - 1) ? 1 : 0);
                if (rd_ready) begin
                    if (nrd == 0) a0 = rd_addr_a;
                    if (nrd == 1) a1 = rd_addr_a;
                    if (i == 1 && j == 2 && k == 3) begin
                        spot_a = rd_addr_a;
                        spot_b = rd_addr_b;
                    end
                    nrd++;
                    if (k == n - 1) ph = 1;
                    else k++;
                end
            end else if (ph == 1) begin
                chk("wr_addr", wr_addr, d + 32'((i * n + j) * 4));
                if (wr_ready) begin
                    last_wr = wr_addr;
                    nwr++;
                    k = 0;
                    ph = 0;
                    if (j < n - 1) begin
                        j++;
                    end else begin
                        j = 0;
                        if (i < n - 1) i++;
                        else ph = 2;
                    end
                end
            end else begin
                ndone++;
                fin = 1;
                cmd_valid = 1'b0;
            end
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        rd_ready  = 1'b0;
        wr_ready  = 1'b0;
        chk("finished", {31'b0, fin}, 1);
        chk("post_ready", cmd_ready, 1);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        src1_addr   = '0;
        src2_addr   = '0;
        dst_addr    = '0;
        matrix_size = '0;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        spot_a = '0; spot_b = '0; last_wr = '0; a0 = '0; a1 = '0;
        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_wrv", wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_a", rd_addr_a, 0);
        chk("rst_b", rd_addr_b, 0);
        chk("rst_w", wr_addr, 0);
        step();
        rst_n = 1'b1;
        step();

        // N=1, stepped by hand
        cmd_valid   = 1'b1;
        src1_addr   = 32'h1000;
        src2_addr   = 32'h2000;
        dst_addr    = 32'h3000;
        matrix_size = 3'd0;
        step();
        cmd_valid = 1'b0;
        chk("n1_rdv", rd_valid, 1);
        chk("n1_a", rd_addr_a, 32'h1000);
        chk("n1_b", rd_addr_b, 32'h2000);
        chk("n1_first", rd_first, 1);
        chk("n1_last", rd_last, 1);
        chk("n1_busy", busy, 1);
        chk("n1_ready", cmd_ready, 0);
        chk("n1_wrv0", wr_valid, 0);
        step();
        chk("n1_hold_rdv", rd_valid, 1);
        chk("n1_hold_a", rd_addr_a, 32'h1000);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("n1_wrv", wr_valid, 1);
        chk("n1_rdv0", rd_valid, 0);
        chk("n1_w", wr_addr, 32'h3000);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        chk("n1_done", done, 1);
        chk("n1_wrv1", wr_valid, 0);
        chk("n1_busyd", busy, 1);
        step();
        chk("n1_done0", done, 0);
        chk("n1_ready1", cmd_ready, 1);
        chk("n1_busy0", busy, 0);

        // N=8 unstalled
        run_cmd(32'h1000, 32'h2000, 32'h3000, 3'd7, 1'b0);
        chk("n8_reads", nrd, 512);
        chk("n8_writes", nwr, 64);
        chk("n8_dones", ndone, 1);
        chk("n8_spot_a", spot_a, 32'h102C);
        chk("n8_spot_b", spot_b, 32'h2068);
        chk("n8_last_wr", last_wr, 32'h30FC);

        // N=8 with random back-pressure
        run_cmd(32'h1000, 32'h2000, 32'h3000, 3'd7, 1'b1);
        chk("st_reads", nrd, 512);
        chk("st_writes", nwr, 64);
        chk("st_dones", ndone, 1);
        chk("st_spot_a", spot_a, 32'h102C);
        chk("st_last_wr", last_wr, 32'h30FC);

        // Address wrap
        run_cmd(32'hFFFFFFFC, 32'h2000, 32'h3000, 3'd1, 1'b0);
        chk("wrap_a0", a0, 32'hFFFFFFFC);
        chk("wrap_a1", a1, 32'h00000000);
        chk("wrap_reads", nrd, 8);
        chk("wrap_writes", nwr, 4);

        // Reset in the middle of a command
        cmd_valid   = 1'b1;
        src1_addr   = 32'h1000;
        src2_addr   = 32'h2000;
        dst_addr    = 32'h3000;
        matrix_size = 3'd7;
        step();
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        repeat (3) step();
        chk("mid_busy", busy, 1);
        chk("mid_a", rd_addr_a, 32'h100C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rdv", rd_valid, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_a", rd_addr_a, 0);
        chk("arst_b", rd_addr_b, 0);
        chk("arst_w", wr_addr, 0);
        chk("arst_done", done, 0);
        rd_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle", busy, 0);
        run_cmd(32'h1000, 32'h2000, 32'h3000, 3'd0, 1'b0);
        chk("after_reads", nrd, 1);
        chk("after_writes", nwr, 1);
        chk("after_dones", ndone, 1);

`ifdef PIM_AGU_ALIGN_CHECK_EN
        cmd_valid   = 1'b1;
        src1_addr   = 32'h1000;
        src2_addr   = 32'h2002;
        dst_addr    = 32'h3000;
        matrix_size = 3'd1;
        step();
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        wr_ready  = 1'b1;
        chk("al_err", err, 1);
        chk("al_ready", cmd_ready, 1);
        chk("al_busy", busy, 0);
        chk("al_rdv", rd_valid, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("al_err0", err, 0);
            chk("al_rdv0", rd_valid, 0);
            chk("al_wrv0", wr_valid, 0);
            chk("al_done0", done, 0);
            chk("al_ready1", cmd_ready, 1);
        end
        rd_ready = 1'b0;
        wr_ready = 1'b0;
        run_cmd(32'h1000, 32'h2000, 32'h3000, 3'd0, 1'b0);
        chk("al_next_dones", ndone, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
